pll_rst_ce_gen: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 15 +
 rtl/lock_sync.sv | 30 +++
 rtl/pll_rst_ce_gen.sv | 122 ++++++++++++
 tb/tb_pll_rst_ce_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset / clock-enable generator.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam int HOLD_CYCLES_DEF = 1024;
  localparam int CE_DIV_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCK_LOSS_MAX   = 255;

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchronizer for asynchronous status flags, cleared by the
// synchronous system reset so a stale level never survives rst.
module lock_sync
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous flag through the flop chain.
  always_ff @(posedge clk) begin
    // NOTE: the chain is reset as well, otherwise a lock seen before rst could
    // shortcut the full hold period after rst releases.
    if (rst) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's previous value.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_rst_ce_gen.sv
// Holds the core in reset until the PLL lock has been stable for HOLD_CYCLES,
// then releases it and generates phase-aligned clk/2 and clk/CE_DIV enables.
// Optional feature: define LOCK_LOSS_CNT_EN to add the saturating
// lock_loss_cnt output counting RUN -> WAIT_LOCK transitions.
module pll_rst_ce_gen
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CE_DIV      = CE_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       core_rst,
  output logic       ce_half,
  output logic       ce_div,
  output logic       running
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int CE_W   = $clog2(CE_DIV);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CE_W-1:0]   r_ce_cnt;
  logic              w_lock_s;
  logic              w_run;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(pll_locked),
    .o_sync (w_lock_s)
  );

  // Sequencer: lock qualification, hold counting and the RUN-phase CE counter.
  // The CE counter is cleared on the same edge that leaves RUN, so no partial
  // enable pulse can follow a lock loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WAIT_LOCK;
      r_hold_cnt <= '0;
      r_ce_cnt   <= '0;
    end else begin
      // NOTE: every branch, including default, assigns a defined next state so
      // an illegal encoding recovers to WAIT_LOCK.
      case (r_state)
        ST_WAIT_LOCK: begin
          r_hold_cnt <= '0;
          r_ce_cnt   <= '0;
          if (w_lock_s) begin
            r_state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          r_ce_cnt <= '0;
          if (!w_lock_s) begin
            r_state    <= ST_WAIT_LOCK;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        ST_RUN: begin
          r_hold_cnt <= '0;
          if (!w_lock_s) begin
            r_state  <= ST_WAIT_LOCK;
            r_ce_cnt <= '0;
          end else if (r_ce_cnt == CE_LAST) begin
            r_ce_cnt <= '0;
          end else begin
            r_ce_cnt <= r_ce_cnt + CE_W'(1);
          end
        end

        default: begin
          r_state    <= ST_WAIT_LOCK;
          r_hold_cnt <= '0;
          r_ce_cnt   <= '0;
        end
      endcase
    end
  end

  // Moore decode from registered state and counter only.
  assign w_run    = (r_state == ST_RUN);
  assign running  = w_run;
  assign core_rst = !w_run;
  assign ce_half  = w_run & r_ce_cnt[0];
  assign ce_div   = w_run & (r_ce_cnt == CE_LAST);

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] r_lock_loss_cnt;

  // Count RUN -> WAIT_LOCK transitions, saturating; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_loss_cnt <= '0;
    end else if (w_run && !w_lock_s && (r_lock_loss_cnt != 8'(LOCK_LOSS_MAX))) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_rst_ce_gen.sv
// Scoreboard bench for pll_rst_ce_gen: stimulus pushes cycle-tagged expected
// outputs, a negedge monitor pops and compares them when their cycle arrives.
module tb_pll_rst_ce_gen;

  localparam int SYNC  = 2;
  localparam int HOLD  = 16;
  localparam int CEDIV = 8;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  logic core_rst;
  logic ce_half;
  logic ce_div;
  logic running;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    int         c;
    logic       chk_out;
    logic [3:0] out;      // {core_rst, running, ce_half, ce_div}
    logic       chk_llc;
    logic [7:0] llc;
  } exp_t;

  exp_t  q[$];
  string q_nm[$];

  pll_rst_ce_gen #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .CE_DIV     (CEDIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .core_rst     (core_rst),
    .ce_half      (ce_half),
    .ce_div       (ce_div),
    .running      (running)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // cyc = number of posedges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_out(input int c, input bit cr, input bit rn, input bit ch,
                          input bit cd, input string nm);
    exp_t e;
    e.c       = c;
    e.chk_out = 1'b1;
    e.out     = {cr, rn, ch, cd};
    e.chk_llc = 1'b0;
    e.llc     = 8'h00;
    q.push_back(e);
    q_nm.push_back(nm);
  endtask

  task automatic push_llc(input int c, input int v, input string nm);
`ifdef LOCK_LOSS_CNT_EN
    exp_t e;
    e.c       = c;
    e.chk_out = 1'b0;
    e.out     = 4'h0;
    e.chk_llc = 1'b1;
    e.llc     = 8'(v);
    q.push_back(e);
    q_nm.push_back({nm, "_llc"});
`else
    if (c < 0 || v < 0 || nm.len() < 0) begin end
`endif
  endtask

  task automatic push_rst_vals(input int c, input string nm);
    push_out(c, 1'b1, 1'b0, 1'b0, 1'b0, nm);
    push_llc(c, 0, nm);
  endtask

  // RUN cycle k (k=1 first): ce_cnt=(k-1)%CEDIV, so ce_half on even k,
  // ce_div on multiples of CEDIV.
  task automatic push_run(input int start, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      push_out(start + k - 1, 1'b0, 1'b1, (k % 2) == 0, (k % CEDIV) == 0, "run_ce");
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin : mon
    exp_t  e;
    string nm;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e  = q.pop_front();
      nm = q_nm.pop_front();
      if (e.c < cyc) check({nm, "_missed"}, 8'(e.c), 8'(cyc));
      if (e.chk_out)
        check(nm, {4'b0, core_rst, running, ce_half, ce_div}, {4'b0, e.out});
`ifdef LOCK_LOSS_CNT_EN
      if (e.chk_llc) check(nm, lock_loss_cnt, e.llc);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s1, d, a, r, s2, s3;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset for 3 edges plus the first cycle after it.
    for (int c = 1; c <= 4; c++) push_rst_vals(c, "reset");
    wait_cyc(3);
    rst = 1'b0;

    // Lock with a 1-cycle glitch at HOLD count 10: hold restarts.
    g = 6;
    wait_cyc(g);
    pll_locked = 1'b1;                         // edge 0 = cycle g+1
    push_out(g + 19, 1'b1, 1'b0, 1'b0, 1'b0, "glitch_no_early_release");
    push_out(g + 32, 1'b1, 1'b0, 1'b0, 1'b0, "glitch_pre_release");
    s1 = g + 33;
    push_run(s1, 1, 20);
    push_llc(s1, 0, "first_run");
    wait_cyc(g + 13);
    pll_locked = 1'b0;
    wait_cyc(g + 14);
    pll_locked = 1'b1;

    // Lock loss in RUN: outputs drop on the third edge after the drop.
    d = s1 + 19;
    wait_cyc(d);
    pll_locked = 1'b0;
    push_run(s1, 21, 22);
    for (int c = d + 3; c <= d + 6; c++)
      push_out(c, 1'b1, 1'b0, 1'b0, 1'b0, "lock_loss");
    push_llc(d + 3, 1, "lock_loss");

    // HOLD abort must not count as a lock loss nor release reset.
    a = d + 6;
    wait_cyc(a);
    pll_locked = 1'b1;
    wait_cyc(a + 5);
    pll_locked = 1'b0;
    push_out(a + 10, 1'b1, 1'b0, 1'b0, 1'b0, "hold_abort");
    push_llc(a + 10, 1, "hold_abort");
    push_out(a + 19, 1'b1, 1'b0, 1'b0, 1'b0, "hold_abort_no_release");

    // Re-lock repeats the full hold period.
    r = a + 10;
    wait_cyc(r);
    pll_locked = 1'b1;
    push_out(r + 18, 1'b1, 1'b0, 1'b0, 1'b0, "relock_pre");
    s2 = r + 19;
    push_run(s2, 1, 6);

    // rst mid-RUN while ce_cnt=5 (RUN cycle 6).
    wait_cyc(s2 + 5);
    rst = 1'b1;
    push_rst_vals(s2 + 6, "rst_mid_run");
    push_rst_vals(s2 + 7, "rst_after");
    wait_cyc(s2 + 6);
    rst = 1'b0;
    // Sync chain was cleared: edge 0 is s2+7, release after s2+25.
    push_out(s2 + 24, 1'b1, 1'b0, 1'b0, 1'b0, "rst_relock_pre");
    s3 = s2 + 25;
    push_run(s3, 1, 9);

`ifdef LOCK_LOSS_CNT_EN
    begin
      int t;
      t = s3 + 8;
      wait_cyc(t);
      for (int n = 1; n <= 300; n++) begin
        pll_locked = 1'b0;
        push_out(t + 3, 1'b1, 1'b0, 1'b0, 1'b0, "sat_loss");
        push_llc(t + 3, (n > 255) ? 255 : n, "sat_loss");
        wait_cyc(t + 3);
        pll_locked = 1'b1;
        push_out(t + 22, 1'b0, 1'b1, 1'b0, 1'b0, "sat_relock");
        wait_cyc(t + 22);
        t = t + 22;
      end
      rst = 1'b1;
      push_rst_vals(t + 1, "sat_rst");
      wait_cyc(t + 1);
      rst = 1'b0;
    end
`endif

    // Drain the scoreboard within a bounded number of cycles.
    begin
      int budget;
      budget = 0;
      @(negedge clk);
      @(negedge clk);
      while (q.size() > 0 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check("scoreboard_drain", 8'(q.size()), 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
